mem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between two requesters: the CPU MEMSTAGE (port C) and a DMA/program loader (port D).
- Sequences each access over a fixed number of memory cycles and returns a one-cycle Done pulse with registered read data.
- Fixed priority to the CPU, with a starvation counter that forces a DMA grant.
- Sits between MEMSTAGE/loader and the data RAM. The CPU control unit holds its memory phase until Cpu_Done.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter between the CPU memory stage (port C)
// and the DMA/program loader (port D). Fixed CPU priority with a
// starvation counter that forces a DMA grant, fixed-latency access
// sequencing, one-cycle Done pulse and registered read data.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access; arbitrate unmasked requests on each rising edge
// ACCESS | memory cycles 0..MEM_LAT-1 for the granted port, Mem_En=1
// DONE   | one-cycle Done pulse to the granted port, Rd_Data valid
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Cpu_Req,
    input  logic              Cpu_WrEn,
    input  logic [ADDR_W-1:0] Cpu_Addr,
    input  logic [31:0]       Cpu_WrData,
    input  logic              Cpu_ByteSel,
    output logic              Cpu_Gnt,
    output logic              Cpu_Done,
    input  logic              Dma_Req,
    input  logic              Dma_WrEn,
    input  logic [ADDR_W-1:0] Dma_Addr,
    input  logic [31:0]       Dma_WrData,
    input  logic              Dma_ByteSel,
    output logic              Dma_Gnt,
    output logic              Dma_Done,
    output logic [31:0]       Rd_Data,
    output logic              Mem_En,
    output logic              Mem_WrEn,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_DataIn,
    output logic              Mem_ByteSel,
    input  logic [31:0]       Mem_DataOut,
    output logic              Busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [STV_W-1:0]   starve_cnt;
    logic               gnt_dma;
    logic               wr_lat;
    logic               mask_cpu;
    logic               mask_dma;
    logic               req_cpu_eff;
    logic               req_dma_eff;
    logic               grant_cpu;
    logic               grant_dma;
    logic               last_cyc;

    // The just-served port is ignored for one IDLE cycle so a stale request
    // held over from the Done cycle cannot be granted a second time.
    assign req_cpu_eff = Cpu_Req & ~mask_cpu;
    assign req_dma_eff = Dma_Req & ~mask_dma;
    assign grant_cpu   = (state == ST_IDLE) & req_cpu_eff &
                         (~req_dma_eff | (starve_cnt != STV_MAX));
    assign grant_dma   = (state == ST_IDLE) & req_dma_eff & ~grant_cpu;
    assign last_cyc    = (cyc_cnt == LAST_CYC);

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_nxt = state;
        Cpu_Gnt   = 1'b0;
        Dma_Gnt   = 1'b0;
        Cpu_Done  = 1'b0;
        Dma_Done  = 1'b0;
        Mem_En    = 1'b0;
        Mem_WrEn  = 1'b0;
        Busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_cpu || grant_dma) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                Busy    = 1'b1;
                Mem_En  = 1'b1;
                Cpu_Gnt = ~gnt_dma;
                Dma_Gnt = gnt_dma;
                if (last_cyc) begin
                    // single write strobe in the final access cycle
                    Mem_WrEn  = wr_lat;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                Busy      = 1'b1;
                Cpu_Done  = ~gnt_dma;
                Dma_Done  = gnt_dma;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Access cycle counter: restarts at grant, advances through ACCESS
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cyc_cnt <= '0;
        end else if (grant_cpu || grant_dma) begin
            cyc_cnt <= '0;
        end else if (state == ST_ACCESS && !last_cyc) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

    // Latch the winner's request fields at grant; they hold while idle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            gnt_dma     <= 1'b0;
            wr_lat      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_DataIn  <= '0;
            Mem_ByteSel <= 1'b0;
        end else if (grant_dma) begin
            gnt_dma     <= 1'b1;
            wr_lat      <= Dma_WrEn;
            Mem_Addr    <= Dma_Addr;
            Mem_DataIn  <= Dma_WrData;
            Mem_ByteSel <= Dma_ByteSel;
        end else if (grant_cpu) begin
            gnt_dma     <= 1'b0;
            wr_lat      <= Cpu_WrEn;
            Mem_Addr    <= Cpu_Addr;
            Mem_DataIn  <= Cpu_WrData;
            Mem_ByteSel <= Cpu_ByteSel;
        end
    end

    // Capture read data at the end of the final access cycle of a read
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Rd_Data <= '0;
        end else if (state == ST_ACCESS && last_cyc && !wr_lat) begin
            Rd_Data <= Mem_DataOut;
        end
    end

    // Starvation counter: counts CPU grants won while DMA was waiting
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            starve_cnt <= '0;
        end else if (grant_dma) begin
            starve_cnt <= '0;
        end else if (grant_cpu) begin
            if (!Dma_Req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STV_MAX) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    // Last-port mask: armed in DONE, live for exactly one IDLE cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mask_cpu <= 1'b0;
            mask_dma <= 1'b0;
        end else if (state == ST_DONE) begin
            mask_cpu <= ~gnt_dma;
            mask_dma <= gnt_dma;
        end else if (state == ST_IDLE) begin
            mask_cpu <= 1'b0;
            mask_dma <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized requesters, all checked every cycle against a
// transaction-timeline reference model.
module tb_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Cpu_Req = 1'b0;
    logic              Cpu_WrEn = 1'b0;
    logic [ADDR_W-1:0] Cpu_Addr = '0;
    logic [31:0]       Cpu_WrData = '0;
    logic              Cpu_ByteSel = 1'b0;
    logic              Dma_Req = 1'b0;
    logic              Dma_WrEn = 1'b0;
    logic [ADDR_W-1:0] Dma_Addr = '0;
    logic [31:0]       Dma_WrData = '0;
    logic              Dma_ByteSel = 1'b0;
    logic [31:0]       Mem_DataOut = '0;
    logic              Cpu_Gnt, Cpu_Done, Dma_Gnt, Dma_Done;
    logic [31:0]       Rd_Data;
    logic              Mem_En, Mem_WrEn, Mem_ByteSel, Busy;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_DataIn;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Cpu_Req(Cpu_Req), .Cpu_WrEn(Cpu_WrEn), .Cpu_Addr(Cpu_Addr),
        .Cpu_WrData(Cpu_WrData), .Cpu_ByteSel(Cpu_ByteSel),
        .Cpu_Gnt(Cpu_Gnt), .Cpu_Done(Cpu_Done),
        .Dma_Req(Dma_Req), .Dma_WrEn(Dma_WrEn), .Dma_Addr(Dma_Addr),
        .Dma_WrData(Dma_WrData), .Dma_ByteSel(Dma_ByteSel),
        .Dma_Gnt(Dma_Gnt), .Dma_Done(Dma_Done),
        .Rd_Data(Rd_Data), .Mem_En(Mem_En), .Mem_WrEn(Mem_WrEn),
        .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn),
        .Mem_ByteSel(Mem_ByteSel), .Mem_DataOut(Mem_DataOut), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one record for the latest transaction, positioned on
    // a timeline of rising edges. ph = edges elapsed since the grant edge:
    // 0..MEM_LAT-1 access, MEM_LAT done, MEM_LAT+1 masked idle.
    int                m_edge = 0;
    int                m_gedge = 0;
    bit                m_live = 1'b0;
    bit                m_dma = 1'b0;
    bit                m_wr = 1'b0;
    bit                m_bs = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_wd = '0;
    logic [31:0]       m_rd = '0;
    int                m_starve = 0;

    // Observation bookkeeping
    string seq = "";
    bit    pc = 1'b0, pd = 1'b0;
    int    n_wren = 0, wr_pos = 0, gnt_run = 0, n_gc = 0, n_gd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_edge = 0; m_gedge = 0; m_live = 0; m_dma = 0; m_wr = 0; m_bs = 0;
        m_addr = '0; m_wd = '0; m_rd = '0; m_starve = 0;
    endtask

    task automatic model_step();
        int ph;
        bit c, d, win_d;
        ph = m_edge - m_gedge;
        if (m_live && ph == MEM_LAT - 1 && !m_wr) m_rd = Mem_DataOut;
        if (!m_live || ph >= MEM_LAT + 1) begin
            c = Cpu_Req && !(m_live && ph == MEM_LAT + 1 && !m_dma);
            d = Dma_Req && !(m_live && ph == MEM_LAT + 1 && m_dma);
            if (c || d) begin
                win_d = d && (!c || m_starve == STARVE_MAX);
                if (win_d) m_starve = 0;
                else if (Dma_Req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
                else m_starve = 0;
                m_live = 1; m_dma = win_d; m_gedge = m_edge + 1;
                m_wr   = win_d ? Dma_WrEn : Cpu_WrEn;
                m_addr = win_d ? Dma_Addr : Cpu_Addr;
                m_wd   = win_d ? Dma_WrData : Cpu_WrData;
                m_bs   = win_d ? Dma_ByteSel : Cpu_ByteSel;
            end
        end
        m_edge++;
    endtask

    task automatic check_all();
        int ph;
        bit act, don, bsy, wre;
        ph  = m_edge - m_gedge;
        act = m_live && ph < MEM_LAT;
        don = m_live && ph == MEM_LAT;
        bsy = m_live && ph <= MEM_LAT;
        wre = m_live && ph == MEM_LAT - 1 && m_wr;
        chk("cpu_gnt",  32'(Cpu_Gnt),  32'(act && !m_dma));
        chk("dma_gnt",  32'(Dma_Gnt),  32'(act && m_dma));
        chk("cpu_done", 32'(Cpu_Done), 32'(don && !m_dma));
        chk("dma_done", 32'(Dma_Done), 32'(don && m_dma));
        chk("mem_en",   32'(Mem_En),   32'(act));
        chk("mem_wren", 32'(Mem_WrEn), 32'(wre));
        chk("busy",     32'(Busy),     32'(bsy));
        chk("rd_data",  Rd_Data,       m_rd);
        chk("mem_addr", 32'(Mem_Addr), 32'(m_addr));
        chk("mem_din",  Mem_DataIn,    m_wd);
        chk("mem_bsel", 32'(Mem_ByteSel), 32'(m_bs));
    endtask

    // One clock: model advances on the rising edge, DUT checked on the falling edge
    task automatic step();
        @(posedge Clk);
        if (!Reset) model_clear(); else model_step();
        @(negedge Clk);
        check_all();
        if (Cpu_Gnt && !pc) begin seq = {seq, "C"}; n_gc++; end
        if (Dma_Gnt && !pd) begin seq = {seq, "D"}; n_gd++; end
        pc = Cpu_Gnt; pd = Dma_Gnt;
        gnt_run = (Cpu_Gnt || Dma_Gnt) ? gnt_run + 1 : 0;
        if (Mem_WrEn) begin n_wren++; wr_pos = gnt_run; end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        model_clear();
        step();
        step();
        Reset = 1'b1;
    endtask

    task automatic wait_done(input bit dma, input string tag);
        for (int i = 0; i < 20; i++) begin
            step();
            if (dma ? Dma_Done : Cpu_Done) break;
        end
        chk(tag, 32'(dma ? Dma_Done : Cpu_Done), 32'd1);
    endtask

    task automatic rnd_port(input logic gnt, input logic done, inout logic req,
                            inout logic hold, inout logic wr,
                            inout logic [ADDR_W-1:0] addr, inout logic [31:0] wd,
                            inout logic bs);
        if (hold) begin
            req = 1'b0; hold = 1'b0;
        end else if (done) begin
            if ($urandom_range(3) == 0) hold = 1'b1; else req = 1'b0;
        end else if (!req) begin
            if ($urandom_range(2) == 0) begin
                req = 1'b1; wr = 1'($urandom_range(1)); addr = ADDR_W'($urandom);
                wd = $urandom; bs = 1'($urandom_range(1));
            end
        end else if (gnt) begin
            if ($urandom_range(7) == 0) req = 1'b0;
            wr = 1'($urandom_range(1)); addr = ADDR_W'($urandom);
            wd = $urandom; bs = 1'($urandom_range(1));
        end
    endtask

    logic c_hold = 1'b0, d_hold = 1'b0;
    bit   cdone_prev = 1'b0;

    initial begin
        // Reset held with both ports requesting, then release: CPU wins first
        Cpu_Req = 1; Cpu_WrEn = 0; Cpu_Addr = 10'h010; Cpu_ByteSel = 0;
        Dma_Req = 1; Dma_WrEn = 1; Dma_Addr = 10'h3FF; Dma_WrData = 32'h0000_00A5; Dma_ByteSel = 1;
        Mem_DataOut = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_outputs", {Rd_Data[31:4], 1'b0, Cpu_Gnt, Dma_Gnt, Busy}, 32'd0);
        end
        Reset = 1'b1;
        n_gc = 0; n_wren = 0;
        step();
        chk("first_gnt_cpu", {31'd0, Cpu_Gnt}, 32'd1);

        // CPU read at 0x010
        wait_done(1'b0, "t2_cpu_done");
        chk("t2_gnt_cycles", 32'(gnt_run == 0 ? MEM_LAT : 0), 32'(MEM_LAT));
        chk("t2_rd_data", Rd_Data, 32'hDEAD_BEEF);
        chk("t2_no_wren", 32'(n_wren), 32'd0);
        Cpu_Req = 0;
        Mem_DataOut = 32'h1234_5678;

        // DMA byte write at 0x3FF granted right after the CPU
        n_wren = 0; wr_pos = 0;
        wait_done(1'b1, "t3_dma_done");
        chk("t3_wren_count", 32'(n_wren), 32'd1);
        chk("t3_wren_pos", 32'(wr_pos), 32'(MEM_LAT));
        chk("t3_addr", 32'(Mem_Addr), 32'h3FF);
        chk("t3_bsel", 32'(Mem_ByteSel), 32'd1);
        chk("t3_rd_hold", Rd_Data, 32'hDEAD_BEEF);
        Dma_Req = 0;
        step();

        // Reset during the first access cycle of a CPU write
        Cpu_Req = 1; Cpu_WrEn = 1; Cpu_Addr = 10'h155; Cpu_WrData = $urandom;
        for (int i = 0; i < 10 && !Cpu_Gnt; i++) step();
        chk("t5_granted", 32'(Cpu_Gnt), 32'd1);
        Reset = 1'b0;
        model_clear();
        n_wren = 0; n_gc = 0;
        pc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_done", 32'(Cpu_Done), 32'd0);
        end
        chk("t5_no_wren", 32'(n_wren), 32'd0);
        chk("t5_busy", 32'(Busy), 32'd0);
        chk("t5_rd_zero", Rd_Data, 32'd0);
        Cpu_Req = 0; Cpu_WrEn = 0;
        Reset = 1'b1;
        step();

        // Stale CPU request after Done must not beat a waiting DMA
        Cpu_Req = 1; Cpu_WrEn = 0; Dma_Req = 1; Dma_WrEn = 0;
        do_reset();
        seq = "";
        wait_done(1'b0, "t6_cpu_done");
        step();
        Cpu_Req = 0;
        wait_done(1'b1, "t6_dma_done");
        Dma_Req = 0;
        for (int i = 0; i < 4; i++) step();
        chk_str("t6_no_regrant", seq, "CD");
        Cpu_Req = 1;
        wait_done(1'b0, "t6_cpu_again");
        Cpu_Req = 0;
        chk_str("t6_seq", seq, "CDC");
        step();

        // Starvation: DMA only drops out during the CPU's masked idle cycle
        Cpu_Req = 1; Dma_Req = 1; cdone_prev = 0;
        do_reset();
        seq = "";
        for (int i = 0; i < 400 && seq.len() < 10; i++) begin
            step();
            Dma_Req = !cdone_prev;
            cdone_prev = Cpu_Done;
        end
        chk_str("t4_starve_seq", seq, "CCCCDCCCCD");
        Cpu_Req = 0; Dma_Req = 0;
        for (int i = 0; i < 6; i++) step();

        // Randomized requesters
        for (int i = 0; i < 800; i++) begin
            rnd_port(Cpu_Gnt, Cpu_Done, Cpu_Req, c_hold, Cpu_WrEn, Cpu_Addr, Cpu_WrData, Cpu_ByteSel);
            rnd_port(Dma_Gnt, Dma_Done, Dma_Req, d_hold, Dma_WrEn, Dma_Addr, Dma_WrData, Dma_ByteSel);
            Mem_DataOut = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
